div_repsub: RTL

Unsigned integer divider that computes quotient and remainder by repeated subtraction. It is the inverse of the team's repeated-addition multiplier. Operands arrive on a shared data_in bus over two consecutive cycles: dividend first, then divisor. A built-in controller FSM drives the datapath registers, subtractor, comparator and quotient counter, and reports completion with a start/busy/done handshake. Intended as a standalone arithmetic unit fed by a sequencer or testbench.

---
 rtl/div_repsub.sv | 88 ++++++++
 1 files changed

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction: the dividend and then the divisor arrive
// on data_in over two cycles; quotient and remainder are held while done is high.
module div_repsub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_B = 2'd1,
      S_RUN    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             dbz_q, dbz_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         d_q     <= '0;
         q_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         d_q     <= d_d;
         q_q     <= q_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      d_d     = d_q;
      q_d     = q_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         // IDLE and DONE accept a new request identically.
         S_IDLE, S_DONE: begin
            if (start) begin
               r_d     = data_in;
               q_d     = '0;
               dbz_d   = 1'b0;
               state_d = S_LOAD_B;
            end
         end
         S_LOAD_B: begin
            d_d     = data_in;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (d_q == '0) begin
               q_d     = '1;
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end else if (r_q >= d_q) begin
               r_d = r_q - d_q;
               q_d = q_q + 1'b1;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign quotient    = q_q;
   assign remainder   = r_q;
   assign busy        = (state_q == S_LOAD_B) || (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q;

endmodule
